cpu_bram_sched: RTL

- Sits between the CPU bus interface (BUS_EN/WE/SELECT/ADDR/DATA) and four single-port BRAM banks.
- Detects each CPU write strobe and queues it once in a 2-deep write FIFO.
- Arbitrates the shared bank port between queued CPU writes and an internal read requester (valid/grant handshake).
- Returns read data through a fixed-latency pipeline.

---
 rtl/cpu_bram_sched_pkg.sv | 15 +
 rtl/cpu_bram_wr_fifo.sv | 38 +++
 rtl/cpu_bram_sched.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_bram_sched_pkg.sv
// cpu_bram_sched_pkg: shared types and constants for the CPU/BRAM scheduler
package cpu_bram_sched_pkg;
  localparam int NUM_BANKS = 4;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  typedef struct packed {
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE} sched_state_t;
  function automatic logic [NUM_BANKS-1:0] onehot(input logic [1:0] s);
    return NUM_BANKS'(1) << s;
  endfunction
endpackage

// File: rtl/cpu_bram_wr_fifo.sv
// cpu_bram_wr_fifo: synchronous FIFO of queued CPU write entries
module cpu_bram_wr_fifo
  import cpu_bram_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wr_entry_t din,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  wr_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign wr = push & ~full;
  assign rd = pop & ~empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  // pointer/count update; storage itself needs no reset
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) mem[wp] <= din;
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/cpu_bram_sched.sv
// cpu_bram_sched: CPU write queue + read arbitration onto 4 BRAM banks; CPU_BRAM_SCHED_DROP_CNT_EN enables WR_DROP_CNT
module cpu_bram_sched
  import cpu_bram_sched_pkg::*;
#(
  parameter int WR_FIFO_DEPTH = 2,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WR_BURST = 4
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic                 BUS_EN,
  input  logic                 BUS_WE,
  input  logic [1:0]           BUS_SELECT,
  input  logic [ADDR_W-1:0]    BUS_ADDR,
  input  logic [DATA_W-1:0]    BUS_DATA,
  input  logic                 RD_REQ,
  input  logic [1:0]           RD_SELECT,
  input  logic [ADDR_W-1:0]    RD_ADDR,
  output logic                 RD_GNT,
  output logic                 RD_VALID,
  output logic [DATA_W-1:0]    RD_DATA,
  output logic [NUM_BANKS-1:0] MEM_EN,
  output logic                 MEM_WE,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  output logic [DATA_W-1:0]    MEM_WDATA,
  input  logic [63:0]          MEM_RDATA,
  output logic [7:0]           WR_DROP_CNT
);
  localparam int BW = $clog2(MAX_WR_BURST + 1) + 1;
  sched_state_t state, state_nxt;
  wr_entry_t head, iss;
  logic s, s_q, push, pop, full, empty;
  logic [BW-1:0] burst;
  logic [RD_LATENCY-1:0] p_v;
  logic [2*RD_LATENCY-1:0] p_s;
  logic [1:0] rs;
  assign s = BUS_EN & BUS_WE;
  assign push = s & ~s_q;
  assign rs = p_s[2*RD_LATENCY-1 -: 2];
  cpu_bram_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_fifo (
    .clk(BUS_CLK),
    .rst(RST),
    .push(push & ~full),
    .pop(pop),
    .din('{sel: BUS_SELECT, addr: BUS_ADDR, data: BUS_DATA}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // arbitration: queued writes win unless a waiting read has hit the burst cap
  always_comb begin
    pop = ~empty & ~(RD_REQ & (burst == BW'(MAX_WR_BURST)));
    RD_GNT = ~pop & RD_REQ;
    state_nxt = pop ? WR_ISSUE : RD_GNT ? RD_ISSUE : IDLE;
  end
  // state register plus the entry being issued next cycle and the burst counter
  always_ff @(posedge BUS_CLK)
    if (RST) begin
      state <= IDLE;
      iss <= '0;
      burst <= '0;
      s_q <= 1'b0;
    end else begin
      state <= state_nxt;
      iss <= pop ? head : '{sel: RD_SELECT, addr: RD_ADDR, data: '0};
      burst <= pop ? burst + BW'(RD_REQ) : '0;
      s_q <= s;
    end
  // bank port is driven only during the issue cycle
  always_comb begin
    MEM_EN = state == IDLE ? '0 : onehot(iss.sel);
    MEM_WE = state == WR_ISSUE;
    MEM_ADDR = state == IDLE ? '0 : iss.addr;
    MEM_WDATA = state == WR_ISSUE ? iss.data : '0;
  end
  // read return: bank select travels alongside the BRAM latency, then data is registered
  always_ff @(posedge BUS_CLK)
    if (RST) begin
      p_v <= '0;
      p_s <= '0;
      RD_VALID <= 1'b0;
      RD_DATA <= '0;
    end else begin
      p_v <= RD_LATENCY'({p_v, state == RD_ISSUE});
      p_s <= (2*RD_LATENCY)'({p_s, iss.sel});
      RD_VALID <= p_v[RD_LATENCY-1];
      if (p_v[RD_LATENCY-1]) RD_DATA <= MEM_RDATA[rs*DATA_W +: DATA_W];
    end
`ifdef CPU_BRAM_SCHED_DROP_CNT_EN
  // saturating count of CPU writes lost to a full FIFO
  always_ff @(posedge BUS_CLK)
    if (RST) WR_DROP_CNT <= '0;
    else if (push & full & ~&WR_DROP_CNT) WR_DROP_CNT <= WR_DROP_CNT + 8'd1;
`else
  assign WR_DROP_CNT = '0;
`endif
endmodule
